jg3_round_ctrl: RTL and testbench

Round controller for the three-judge panel. It opens a fixed-length voting window, collects sticky votes from judges A, B and C into a 3-bit ABC word, and then classifies the word: X = pass (A voted), Y = unanimous reject (no votes). It also keeps saturating pass and reject tallies across rounds. It sits between the panel's vote inputs and the display/score logic, and adds the window timing and bookkeeping that the plain combinational judge lacks.

---
 rtl/jg3_round_ctrl_if.sv | 26 ++
 rtl/jg3_round_ctrl.sv | 94 +++++++++
 tb/tb_jg3_round_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/jg3_round_ctrl_if.sv
// rtl/jg3_round_ctrl_if.sv - vote/result bundle between the judge panel and the round controller
interface jg3_round_ctrl_if #(
   parameter int CNT_W = 8
);
   logic             start;
   logic             vote_a;
   logic             vote_b;
   logic             vote_c;
   logic             busy;
   logic [2:0]       ABC;
   logic             X;
   logic             Y;
   logic             done;
   logic [CNT_W-1:0] pass_cnt;
   logic [CNT_W-1:0] reject_cnt;

   modport master (
      output start, vote_a, vote_b, vote_c,
      input  busy, ABC, X, Y, done, pass_cnt, reject_cnt
   );

   modport slave (
      input  start, vote_a, vote_b, vote_c,
      output busy, ABC, X, Y, done, pass_cnt, reject_cnt
   );
endinterface

// File: rtl/jg3_round_ctrl.sv
// rtl/jg3_round_ctrl.sv - three-judge round controller: timed vote window, classification, saturating tallies
module jg3_round_ctrl #(
   parameter int WINDOW = 8,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   jg3_round_ctrl_if.slave  bus
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_VOTE = 2'd1;
   localparam logic [1:0] S_EVAL = 2'd2;

   localparam logic [7:0]       TIMER_LOAD = 8'(WINDOW - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;

   logic [1:0]       state;
   logic [7:0]       timer;
   logic [2:0]       abc;
   logic             x;
   logic             y;
   logic             done;
   logic             busy;
   logic [CNT_W-1:0] pass_cnt;
   logic [CNT_W-1:0] reject_cnt;

   logic [2:0]       votes;
   logic             new_x;
   logic             new_y;

   assign votes = {bus.vote_a, bus.vote_b, bus.vote_c};
   assign new_x = abc[2];
   assign new_y = (abc == 3'b000);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         timer      <= 8'd0;
         abc        <= 3'b000;
         x          <= 1'b0;
         y          <= 1'b0;
         done       <= 1'b0;
         busy       <= 1'b0;
         pass_cnt   <= '0;
         reject_cnt <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  state <= S_VOTE;
                  busy  <= 1'b1;
                  abc   <= 3'b000;
                  timer <= TIMER_LOAD;
               end
            end
            S_VOTE: begin
               // The timer==0 edge still contributes its votes before leaving VOTE.
               abc <= abc | votes;
               if (timer == 8'd0) begin
                  state <= S_EVAL;
               end else begin
                  timer <= timer - 8'd1;
               end
            end
            S_EVAL: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               x     <= new_x;
               y     <= new_y;
               done  <= 1'b1;
               if (new_x && (pass_cnt != CNT_MAX)) begin
                  pass_cnt <= pass_cnt + 1'b1;
               end
               if (new_y && (reject_cnt != CNT_MAX)) begin
                  reject_cnt <= reject_cnt + 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy       = busy;
   assign bus.ABC        = abc;
   assign bus.X          = x;
   assign bus.Y          = y;
   assign bus.done       = done;
   assign bus.pass_cnt   = pass_cnt;
   assign bus.reject_cnt = reject_cnt;
endmodule

// File: tb/tb_jg3_round_ctrl.sv
// tb/tb_jg3_round_ctrl.sv - directed table-driven bench for jg3_round_ctrl
module tb_jg3_round_ctrl;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   jg3_round_ctrl_if #(.CNT_W(8)) bus ();
   jg3_round_ctrl_if #(.CNT_W(2)) sbus ();

   assign sbus.start  = bus.start;
   assign sbus.vote_a = bus.vote_a;
   assign sbus.vote_b = bus.vote_b;
   assign sbus.vote_c = bus.vote_c;

   jg3_round_ctrl #(.WINDOW(W), .CNT_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   jg3_round_ctrl #(.WINDOW(W), .CNT_W(2)) dut_sat (
      .clk (clk),
      .rst (rst),
      .bus (sbus)
   );

   typedef struct {
      string      name;
      logic [7:0] ma;
      logic [7:0] mb;
      logic [7:0] mc;
      logic [2:0] ext;
      logic [2:0] abc;
      logic       x;
      logic       y;
   } vec_t;

   vec_t vecs[7];

   int checks = 0;
   int errors = 0;
   int exp_pass = 0;
   int exp_rej = 0;
   int exp_spass = 0;
   int exp_srej = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_votes(input logic a, input logic b, input logic c);
      bus.vote_a = a;
      bus.vote_b = b;
      bus.vote_c = c;
   endtask

   task automatic run_round(input vec_t v);
      bus.start = 1'b1;
      set_votes(1'b0, 1'b0, 1'b0);
      tick();
      bus.start = 1'b0;
      chk({v.name, " busy_at_start"}, 32'(bus.busy), 32'd1);
      for (int k = 1; k <= W; k++) begin
         set_votes(v.ma[k-1], v.mb[k-1], v.mc[k-1]);
         tick();
         chk({v.name, " done_early"}, 32'(bus.done), 32'd0);
      end
      set_votes(v.ext[2], v.ext[1], v.ext[0]);
      tick();
      set_votes(1'b0, 1'b0, 1'b0);
      if (v.x) exp_pass++;
      if (v.y) exp_rej++;
      if (v.x && exp_spass < 3) exp_spass++;
      if (v.y && exp_srej < 3) exp_srej++;
      chk({v.name, " done"}, 32'(bus.done), 32'd1);
      chk({v.name, " busy_end"}, 32'(bus.busy), 32'd0);
      chk({v.name, " abc"}, 32'(bus.ABC), 32'(v.abc));
      chk({v.name, " x"}, 32'(bus.X), 32'(v.x));
      chk({v.name, " y"}, 32'(bus.Y), 32'(v.y));
      chk({v.name, " pass_cnt"}, 32'(bus.pass_cnt), 32'(exp_pass));
      chk({v.name, " reject_cnt"}, 32'(bus.reject_cnt), 32'(exp_rej));
      chk({v.name, " sat_pass_cnt"}, 32'(sbus.pass_cnt), 32'(exp_spass));
      chk({v.name, " sat_reject_cnt"}, 32'(sbus.reject_cnt), 32'(exp_srej));
      tick();
      chk({v.name, " done_one_cycle"}, 32'(bus.done), 32'd0);
      chk({v.name, " abc_hold"}, 32'(bus.ABC), 32'(v.abc));
      chk({v.name, " x_hold"}, 32'(bus.X), 32'(v.x));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      exp_pass = 0;
      exp_rej = 0;
      exp_spass = 0;
      exp_srej = 0;
   endtask

   initial begin
      vec_t va;
      int   done_seen;

      vecs[0] = '{"no_vote",     8'h00, 8'h00, 8'h00, 3'b000, 3'b000, 1'b0, 1'b1};
      vecs[1] = '{"a_last_edge", 8'h80, 8'h00, 8'h00, 3'b000, 3'b100, 1'b1, 1'b0};
      vecs[2] = '{"a_too_late",  8'h00, 8'h00, 8'h00, 3'b100, 3'b000, 1'b0, 1'b1};
      vecs[3] = '{"split_panel", 8'h00, 8'h02, 8'h10, 3'b000, 3'b011, 1'b0, 1'b0};
      vecs[4] = '{"all_first",   8'h01, 8'h01, 8'h01, 3'b000, 3'b111, 1'b1, 1'b0};
      vecs[5] = '{"c_held",      8'h00, 8'h00, 8'hff, 3'b000, 3'b001, 1'b0, 1'b0};
      vecs[6] = '{"b_first_c_late", 8'h00, 8'h01, 8'h00, 3'b001, 3'b010, 1'b0, 1'b0};

      bus.start = 1'b0;
      set_votes(1'b0, 1'b0, 1'b0);
      do_reset();

      chk("reset busy", 32'(bus.busy), 32'd0);
      chk("reset abc", 32'(bus.ABC), 32'd0);
      chk("reset x", 32'(bus.X), 32'd0);
      chk("reset y", 32'(bus.Y), 32'd0);
      chk("reset done", 32'(bus.done), 32'd0);
      chk("reset pass_cnt", 32'(bus.pass_cnt), 32'd0);
      chk("reset reject_cnt", 32'(bus.reject_cnt), 32'd0);

      for (int i = 0; i < 7; i++) begin
         run_round(vecs[i]);
      end

      // Votes while idle must not touch the latched word or results.
      set_votes(1'b1, 1'b1, 1'b1);
      tick();
      tick();
      set_votes(1'b0, 1'b0, 1'b0);
      chk("idle_votes abc", 32'(bus.ABC), 32'(vecs[6].abc));
      chk("idle_votes x", 32'(bus.X), 32'd0);
      chk("idle_votes busy", 32'(bus.busy), 32'd0);

      // start held high: rounds must run back-to-back with period W+2.
      bus.start = 1'b1;
      tick();
      chk("hold busy_k0", 32'(bus.busy), 32'd1);
      done_seen = 0;
      for (int k = 1; k <= 2 * W + 3; k++) begin
         tick();
         if (k == 2 * W + 3) bus.start = 1'b0;
         chk($sformatf("hold done_k%0d", k), 32'(bus.done),
             32'((k == W + 1) || (k == 2 * W + 3)));
         chk($sformatf("hold busy_k%0d", k), 32'(bus.busy),
             32'(!((k == W + 1) || (k == 2 * W + 3))));
         if (bus.done) done_seen++;
      end
      chk("hold done_count", 32'(done_seen), 32'd2);
      exp_rej += 2;
      chk("hold reject_cnt", 32'(bus.reject_cnt), 32'(exp_rej));
      tick();
      chk("hold idle_after", 32'(bus.busy), 32'd0);

      // Saturation on the CNT_W=2 instance.
      do_reset();
      va = '{"sat", 8'hff, 8'h00, 8'h00, 3'b000, 3'b100, 1'b1, 1'b0};
      for (int r = 1; r <= 5; r++) begin
         run_round(va);
         chk($sformatf("sat_seq round%0d", r), 32'(sbus.pass_cnt), 32'((r < 3) ? r : 3));
      end

      // Reset in the middle of the vote window discards the round.
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      set_votes(1'b1, 1'b0, 1'b0);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst busy", 32'(bus.busy), 32'd0);
      chk("midrst abc", 32'(bus.ABC), 32'd0);
      chk("midrst pass_cnt", 32'(bus.pass_cnt), 32'd0);
      chk("midrst reject_cnt", 32'(bus.reject_cnt), 32'd0);
      chk("midrst x", 32'(bus.X), 32'd0);
      done_seen = 0;
      for (int k = 0; k < W + 4; k++) begin
         tick();
         if (bus.done || bus.busy) done_seen++;
      end
      set_votes(1'b0, 1'b0, 1'b0);
      chk("midrst no_done", 32'(done_seen), 32'd0);
      chk("midrst abc_still", 32'(bus.ABC), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
